uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmit PISO/FSM datapath between NUM_REQ independent byte producers.
- Selects a requester and captures its byte, then pulses the datapath send input. Waits for the datapath frame-complete indication, then inserts an inter-frame gap before arbitrating again.
- Sits between the requester FIFOs/host interfaces and the UART TX shift datapath, clocked by the baud clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width forwarded to the datapath.
- GAP_CYCLES, 1, idle baud cycles inserted after each frame (0 allowed = no gap).
- TIMEOUT, 16, max BUSY cycles before abort (used only with UART_TX_ARB_TIMEOUT_EN).

Ports:
- baud_clk  in  1  single clock, all logic posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level, held until ack.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; slice i = bits [i*DATA_W +: DATA_W]; stable while req[i]=1.
- ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i captured.
- tx_data  out  DATA_W  registered byte to datapath, held through the frame.
- tx_send  out  1  one-cycle pulse starting a datapath frame.
- tx_done  in  1  one-cycle frame-complete pulse from datapath (count_full).
- grant_id  out  clog2(NUM_REQ)  index of current/last granted requester.
- busy  out  1  high whenever state != IDLE.
- tx_err  out  1  one-cycle timeout pulse (only with UART_TX_ARB_TIMEOUT_EN, else tied 0).

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - state=IDLE; ack=0, tx_send=0, tx_data=0, grant_id=0, busy=0, tx_err=0.
  - rr pointer=0; gap counter=0.
  - Reset mid-frame aborts with no ack or tx_send emitted afterwards.
- States: IDLE, BUSY, GAP.
- IDLE:
  - At a posedge where any req=1, grant g = first i with req[i]=1, searching from pointer, pointer+1, ... mod NUM_REQ.
  - Same edge: tx_data<=req_data[g], grant_id<=g, ack[g]<=1, tx_send<=1, pointer<=(g+1) mod NUM_REQ, state<=BUSY.
  - Latency: req sampled at edge k, so ack/tx_send are high in cycle k..k+1.
  - No req: stay in IDLE, all pulses 0.
- BUSY:
  - ack and tx_send are high only in the first BUSY cycle and clear at the next edge.
  - tx_done is ignored in the cycle where tx_send=1; sampled in every later BUSY cycle.
  - On tx_done=1: GAP_CYCLES>0 goes to GAP with the counter loaded to GAP_CYCLES-1; GAP_CYCLES=0 goes directly to IDLE.
- GAP:
  - Counter decrements each cycle; when 0, go to IDLE.
  - req is not sampled in GAP.
  - Spacing: the next tx_send occurs no earlier than GAP_CYCLES+1 cycles after the tx_done edge.
- tx_done in IDLE or GAP: ignored, no state change.
- A requester may drop req before ack (withdrawal); arbitration samples only in IDLE.
- tx_data and grant_id hold their last value outside BUSY.
- Simultaneous requests are resolved by the rr pointer only. Continuous all-high req yields grants 0,1,...,NUM_REQ-1,0,...
- NUM_REQ=1: pointer stays 0.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With it defined:
  - A watchdog counter clears on BUSY entry and increments each BUSY cycle.
  - If it reaches TIMEOUT with no tx_done: tx_err pulses one cycle, state goes to IDLE (no GAP), and the pointer stays already advanced.
  - A tx_done arriving in the same cycle the counter reaches TIMEOUT wins: normal completion, no tx_err.
- Without it: no watchdog logic, tx_err tied 0, and BUSY waits indefinitely for tx_done.

Test Plan:
- Single request: reset; req=4'b0010, req_data[1]=8'hA5 -> next cycle ack=4'b0010, tx_send=1, tx_data=A5, grant_id=1, busy=1; tx_done 10 cycles later -> one GAP cycle, then busy=0.
- Contention: req=4'b1111 held, tx_done after each frame -> grant_id sequence 0,1,2,3,0; exactly one ack bit per frame; GAP_CYCLES=1 spacing between tx_done and next tx_send.
- Pointer fairness: grant 2 completes, then req=4'b0101 -> next grant is 0 (search from 3 wraps past 3 to 0), then 2.
- Spurious/early tx_done: tx_done=1 in IDLE and in the tx_send cycle -> no state change; frame ends only on a later tx_done.
- Reset mid-frame: assert rst_n=0 in BUSY -> all outputs 0 immediately; after release with req=4'b1000, grant_id=3 (pointer reset to 0, search 0..3).
- Timeout (macro on, TIMEOUT=16): grant with tx_done never asserted -> tx_err pulses in the 16th BUSY cycle, busy=0 next cycle; macro off -> busy stays 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler feeding one shared UART TX datapath from NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to enable the BUSY watchdog and the tx_err pulse.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 16,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      baud_clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_send,
    input  logic                      tx_done,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      tx_err
);

    localparam int unsigned NR       = NUM_REQ;
    localparam int          CNT_MAX  = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
    localparam int          CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int          GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_GAP
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   w_ack_nx;
    logic                 r_tx_send;
    logic                 w_send_nx;
    logic [DATA_W-1:0]    r_tx_data;
    logic [DATA_W-1:0]    w_data_nx;
    logic [ID_W-1:0]      r_grant_id;
    logic [ID_W-1:0]      w_gid_nx;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      w_ptr_nx;
    logic                 r_busy;
    // Gap countdown and BUSY watchdog are never live together, so they share one counter.
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nx;
    logic                 w_found;
    logic [ID_W-1:0]      w_grant;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic                 r_tx_err;
    logic                 w_err_nx;
`endif

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int unsigned off = 0; off < NR; off++) begin
            int unsigned v_idx;
            v_idx = (32'(r_ptr) + off) % NR;
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_grant = ID_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ack_nx   = '0;
        w_send_nx  = 1'b0;
        w_data_nx  = r_tx_data;
        w_gid_nx   = r_grant_id;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_err_nx   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_data_nx  = req_data[int'(w_grant)*DATA_W +: DATA_W];
                    w_gid_nx   = w_grant;
                    w_ack_nx   = NUM_REQ'(1) << w_grant;
                    w_send_nx  = 1'b1;
                    w_ptr_nx   = ID_W'((32'(w_grant) + 32'd1) % NR);
                    w_cnt_nx   = '0;
                    w_state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                // tx_done is only honoured once the tx_send pulse has gone
                if (!r_tx_send && tx_done) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nx = S_GAP;
                        w_cnt_nx   = CNT_W'(GAP_LOAD);
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
`endif
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ack      <= '0;
            r_tx_send  <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_ack      <= w_ack_nx;
            r_tx_send  <= w_send_nx;
            r_tx_data  <= w_data_nx;
            r_grant_id <= w_gid_nx;
            r_ptr      <= w_ptr_nx;
            r_busy     <= (w_state_nx != S_IDLE);
            r_cnt      <= w_cnt_nx;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_err <= 1'b0;
        end else begin
            r_tx_err <= w_err_nx;
        end
    end

    assign tx_err = r_tx_err;
`else
    assign tx_err = 1'b0;
`endif

    assign ack      = r_ack;
    assign tx_send  = r_tx_send;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 1;
    localparam int TMO = 16;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            baud_clk = 1'b0;
    logic            rst_n    = 1'b1;
    logic [N-1:0]    req      = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            tx_done  = 1'b0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   tx_data;
    logic            tx_send;
    logic [1:0]      grant_id;
    logic            busy;
    logic            tx_err;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .DATA_W     (DW),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .baud_clk (baud_clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_done  (tx_done),
        .grant_id (grant_id),
        .busy     (busy),
        .tx_err   (tx_err)
    );

    always #5 baud_clk = ~baud_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: frame age, remaining gap cycles and the next search start.
    int            m_ptr;
    bit            m_in_frame;
    int            m_age;
    int            m_gap_left;
    logic [N-1:0]  e_ack;
    logic          e_send;
    logic [DW-1:0] e_data;
    logic [1:0]    e_gid;
    logic          e_busy;
    logic          e_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_in_frame = 1'b0; m_age = 0; m_gap_left = 0;
        e_ack = '0; e_send = 1'b0; e_data = '0; e_gid = '0; e_busy = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_step();
        bit found;
        e_ack  = '0;
        e_send = 1'b0;
        e_err  = 1'b0;
        if (m_in_frame) begin
            if (m_age > 1 && tx_done) begin
                m_in_frame = 1'b0;
                m_gap_left = GAP;
            end else if (TO_EN && m_age == TMO) begin
                m_in_frame = 1'b0;
                m_gap_left = 0;
                e_err      = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!found && req[i]) begin
                    found      = 1'b1;
                    e_data     = req_data[i*DW +: DW];
                    e_gid      = 2'(i);
                    e_ack[i]   = 1'b1;
                    e_send     = 1'b1;
                    m_ptr      = (i + 1) % N;
                    m_in_frame = 1'b1;
                    m_age      = 1;
                end
            end
        end
        e_busy = m_in_frame || (m_gap_left > 0);
    endtask

    task automatic check_outputs();
        check_val("ack",      32'(ack),      32'(e_ack));
        check_val("tx_send",  32'(tx_send),  32'(e_send));
        check_val("tx_data",  32'(tx_data),  32'(e_data));
        check_val("grant_id", 32'(grant_id), 32'(e_gid));
        check_val("busy",     32'(busy),     32'(e_busy));
        check_val("tx_err",   32'(tx_err),   32'(e_err));
    endtask

    task automatic tick();
        model_step();
        @(posedge baud_clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge baud_clk);
        @(negedge baud_clk);
        rst_n = 1'b1;
    endtask

    task automatic finish_frame(input int n);
        repeat (n) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
    endtask

    initial begin
        int  gap_cnt;
        bit  got;

        #3;
        do_reset();

        // single request
        req_data = 32'h1122_A533;
        req      = 4'b0010;
        tick();
        check_val("single_ack",  32'(ack),      32'h2);
        check_val("single_send", 32'(tx_send),  32'h1);
        check_val("single_data", 32'(tx_data),  32'hA5);
        check_val("single_gid",  32'(grant_id), 32'h1);
        req = '0;
        repeat (9) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_val("single_gap_busy", 32'(busy), 32'h1);
        tick();
        check_val("single_idle_busy", 32'(busy), 32'h0);

        // contention with all requesters high
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            gap_cnt = 0;
            got     = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                tick();
                gap_cnt++;
                if (tx_send) got = 1'b1;
            end
            check_val("rr_send_seen", 32'(got), 32'h1);
            check_val("rr_gid", 32'(grant_id), 32'(f % N));
            check_val("rr_ack", 32'(ack), 32'(1 << (f % N)));
            if (f > 0) check_val("rr_spacing", 32'(gap_cnt), 32'(GAP + 1));
            repeat (3) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        req = '0;
        repeat (2) tick();

        // pointer fairness: after grant 2, search starts at 3 and wraps to 0
        do_reset();
        req_data = 32'h0012_0010;
        req_data[2*DW +: DW] = 8'h5C;
        req = 4'b0100;
        tick();
        check_val("fair_first_gid", 32'(grant_id), 32'h2);
        req = '0;
        finish_frame(3);
        req_data[2*DW +: DW] = 8'h12;
        req = 4'b0101;
        tick();
        check_val("fair_wrap_gid",  32'(grant_id), 32'h0);
        check_val("fair_wrap_data", 32'(tx_data),  32'h10);
        req[0] = 1'b0;
        finish_frame(2);
        tick();
        check_val("fair_next_gid", 32'(grant_id), 32'h2);
        req = '0;
        finish_frame(2);

        // spurious tx_done in IDLE, in the tx_send cycle and in GAP
        tx_done = 1'b1;
        tick();
        check_val("spur_idle_busy", 32'(busy), 32'h0);
        req_data[0 +: DW] = 8'h77;
        req     = 4'b0001;
        tx_done = 1'b0;
        tick();
        req     = '0;
        tx_done = 1'b1;
        tick();
        check_val("spur_send_busy", 32'(busy), 32'h1);
        tx_done = 1'b0;
        repeat (2) tick();
        check_val("spur_hold_busy", 32'(busy), 32'h1);
        tx_done = 1'b1;
        tick();
        tick();
        check_val("spur_gap_ignored", 32'(busy), 32'h0);
        tx_done = 1'b0;
        tick();

        // reset in the middle of a frame
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        do_reset();
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_gid",  32'(grant_id), 32'h0);
        req_data[3*DW +: DW] = 8'hC3;
        req = 4'b1000;
        tick();
        check_val("rst_regrant_gid", 32'(grant_id), 32'h3);
        check_val("rst_regrant_ack", 32'(ack), 32'h8);
        req = '0;
        finish_frame(4);

        // frame whose datapath never reports completion
        req = 4'b0001;
        tick();
        req = '0;
        repeat (TMO - 1) tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
        check_val("tmo_pre_busy", 32'(busy),   32'h1);
        check_val("tmo_pre_err",  32'(tx_err), 32'h0);
        tick();
        check_val("tmo_err",  32'(tx_err), 32'h1);
        check_val("tmo_busy", 32'(busy),   32'h0);
        tick();
        check_val("tmo_err_clear", 32'(tx_err), 32'h0);
`else
        repeat (40) tick();
        check_val("no_tmo_busy", 32'(busy), 32'h1);
        finish_frame(0);
`endif

        // random traffic: requesters hold until ack, occasionally withdraw
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 4 == 0)) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = 8'($urandom);
                end else if (req[i] && ($urandom % 40 == 0)) begin
                    req[i] = 1'b0;
                end
            end
            tx_done = ($urandom % 5 == 0);
            tick();
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) req[i] = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
